// File: rtl/toe_cam_pkg.sv
// rtl/toe_cam_pkg.sv - shared constants and arbitration helper for the ToeCam arbiter
package toe_cam_pkg;
   localparam int K = 96;
   localparam int V = 14;

   localparam logic SRC_RX  = 1'b0;
   localparam logic SRC_TX  = 1'b1;
   localparam logic SRC_INS = 1'b0;
   localparam logic SRC_DEL = 1'b1;

   localparam logic OP_INSERT = 1'b0;
   localparam logic OP_DELETE = 1'b1;

   // Two-way round-robin pick; prio names the client preferred when both request.
   function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic prio);
      logic [1:0] g;
      g = 2'b00;
      if (req == 2'b01)
         g = 2'b01;
      else if (req == 2'b10)
         g = 2'b10;
      else if (req == 2'b11)
         g = prio ? 2'b10 : 2'b01;
      return g;
   endfunction
endpackage

// File: rtl/toe_cam_tag_fifo.sv
// rtl/toe_cam_tag_fifo.sv - in-order source tag FIFO for outstanding CAM lookups
module toe_cam_tag_fifo #(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     push_data,
   input  logic                     pop,
   output logic                     pop_data,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);

   logic [DEPTH-1:0] mem_q, mem_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   always_comb begin
      do_push  = push && !full;
      do_pop   = pop && !empty;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop)
         rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // DEPTH is a power of two, so the count MSB alone marks full.
   assign full     = count_q[AW];
   assign empty    = (count_q == '0);
   assign count    = count_q;
   assign pop_data = mem_q[rd_ptr_q];
endmodule

// File: rtl/toe_cam_arbiter.sv
// rtl/toe_cam_arbiter.sv - round-robin sharing of the ToeCam lookup and update ports
module toe_cam_arbiter
   import toe_cam_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                     Clk,
   input  logic                     Rst,
   input  logic                     CamInitDone,
   input  logic [1:0]               LkpReqValid,
   input  logic [2*K-1:0]           LkpReqKey,
   output logic [1:0]               LkpReqReady,
   output logic                     LookupReqValid,
   output logic [K-1:0]             LookupReqKey,
   input  logic                     LookupRespValid,
   input  logic                     LookupRespHit,
   input  logic [K-1:0]             LookupRespKey,
   input  logic [V-1:0]             LookupRespValue,
   output logic [1:0]               LkpRespValid,
   output logic                     LkpRespHit,
   output logic [K-1:0]             LkpRespKey,
   output logic [V-1:0]             LkpRespValue,
   input  logic [1:0]               UpdReqValid,
   input  logic [1:0]               UpdReqOp,
   input  logic [2*K-1:0]           UpdReqKey,
   input  logic [1:0]               UpdReqStatic,
   input  logic [2*V-1:0]           UpdReqValue,
   output logic [1:0]               UpdReqReady,
   input  logic                     UpdateReady,
   output logic                     UpdateValid,
   output logic                     UpdateOp,
   output logic [K-1:0]             UpdateKey,
   output logic                     UpdateStatic,
   output logic [V-1:0]             UpdateValue,
   output logic [$clog2(DEPTH):0]   Outstanding,
   output logic                     ProtoErr
);
   localparam int AW = $clog2(DEPTH);

   logic [1:0]   lkp_gnt, upd_gnt;
   logic         tag_push, tag_pop, tag_out, tag_empty, tag_full;
   logic [AW:0]  tag_count;

   logic         lkp_prio_q, lkp_prio_d;
   logic         upd_prio_q, upd_prio_d;
   logic         req_valid_q, req_valid_d;
   logic [K-1:0] req_key_q, req_key_d;
   logic [1:0]   resp_valid_q, resp_valid_d;
   logic         resp_hit_q, resp_hit_d;
   logic [K-1:0] resp_key_q, resp_key_d;
   logic [V-1:0] resp_value_q, resp_value_d;
   logic         proto_err_q, proto_err_d;
   logic         slot_full_q, slot_full_d;
   logic         slot_op_q, slot_op_d;
   logic [K-1:0] slot_key_q, slot_key_d;
   logic         slot_static_q, slot_static_d;
   logic [V-1:0] slot_value_q, slot_value_d;

   toe_cam_tag_fifo #(.DEPTH(DEPTH)) u_tag_fifo (
      .clk       (Clk),
      .rst       (Rst),
      .push      (tag_push),
      .push_data (lkp_gnt[1]),
      .pop       (tag_pop),
      .pop_data  (tag_out),
      .empty     (tag_empty),
      .full      (tag_full),
      .count     (tag_count)
   );

   always_comb begin
      lkp_gnt  = (CamInitDone && !tag_full) ? rr_pick(LkpReqValid, lkp_prio_q) : 2'b00;
      tag_push = |lkp_gnt;
      tag_pop  = LookupRespValid && !tag_empty;

      lkp_prio_d  = lkp_prio_q;
      req_valid_d = |lkp_gnt;
      req_key_d   = req_key_q;
      if (lkp_gnt[1]) begin
         req_key_d  = LkpReqKey[K +: K];
         lkp_prio_d = 1'b0;
      end else if (lkp_gnt[0]) begin
         req_key_d  = LkpReqKey[0 +: K];
         lkp_prio_d = 1'b1;
      end

      resp_valid_d = 2'b00;
      resp_hit_d   = resp_hit_q;
      resp_key_d   = resp_key_q;
      resp_value_d = resp_value_q;
      if (tag_pop) begin
         resp_valid_d = (tag_out == SRC_TX) ? 2'b10 : 2'b01;
         resp_hit_d   = LookupRespHit;
         resp_key_d   = LookupRespKey;
         resp_value_d = LookupRespValue;
      end
      // A response with nothing outstanding means the CAM and arbiter disagree.
      proto_err_d = proto_err_q || (LookupRespValid && tag_empty);
   end

   always_comb begin
      upd_gnt       = (CamInitDone && !slot_full_q) ? rr_pick(UpdReqValid, upd_prio_q) : 2'b00;
      upd_prio_d    = upd_prio_q;
      slot_full_d   = slot_full_q;
      slot_op_d     = slot_op_q;
      slot_key_d    = slot_key_q;
      slot_static_d = slot_static_q;
      slot_value_d  = slot_value_q;
      if (slot_full_q && UpdateReady) begin
         slot_full_d = 1'b0;
      end else if (|upd_gnt) begin
         slot_full_d   = 1'b1;
         upd_prio_d    = upd_gnt[0];
         slot_op_d     = upd_gnt[1] ? UpdReqOp[1] : UpdReqOp[0];
         slot_key_d    = upd_gnt[1] ? UpdReqKey[K +: K] : UpdReqKey[0 +: K];
         slot_static_d = upd_gnt[1] ? UpdReqStatic[1] : UpdReqStatic[0];
         slot_value_d  = upd_gnt[1] ? UpdReqValue[V +: V] : UpdReqValue[0 +: V];
      end
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         lkp_prio_q    <= 1'b0;
         upd_prio_q    <= 1'b0;
         req_valid_q   <= 1'b0;
         req_key_q     <= '0;
         resp_valid_q  <= 2'b00;
         resp_hit_q    <= 1'b0;
         resp_key_q    <= '0;
         resp_value_q  <= '0;
         proto_err_q   <= 1'b0;
         slot_full_q   <= 1'b0;
         slot_op_q     <= 1'b0;
         slot_key_q    <= '0;
         slot_static_q <= 1'b0;
         slot_value_q  <= '0;
      end else begin
         lkp_prio_q    <= lkp_prio_d;
         upd_prio_q    <= upd_prio_d;
         req_valid_q   <= req_valid_d;
         req_key_q     <= req_key_d;
         resp_valid_q  <= resp_valid_d;
         resp_hit_q    <= resp_hit_d;
         resp_key_q    <= resp_key_d;
         resp_value_q  <= resp_value_d;
         proto_err_q   <= proto_err_d;
         slot_full_q   <= slot_full_d;
         slot_op_q     <= slot_op_d;
         slot_key_q    <= slot_key_d;
         slot_static_q <= slot_static_d;
         slot_value_q  <= slot_value_d;
      end
   end

   assign LkpReqReady    = lkp_gnt;
   assign LookupReqValid = req_valid_q;
   assign LookupReqKey   = req_key_q;
   assign LkpRespValid   = resp_valid_q;
   assign LkpRespHit     = resp_hit_q;
   assign LkpRespKey     = resp_key_q;
   assign LkpRespValue   = resp_value_q;
   assign UpdReqReady    = upd_gnt;
   assign UpdateValid    = slot_full_q;
   assign UpdateOp       = slot_op_q;
   assign UpdateKey      = slot_key_q;
   assign UpdateStatic   = slot_static_q;
   assign UpdateValue    = slot_value_q;
   assign Outstanding    = tag_count;
   assign ProtoErr       = proto_err_q;
endmodule

// File: tb/tb_toe_cam_arbiter.sv
// tb/tb_toe_cam_arbiter.sv - scoreboard bench for toe_cam_arbiter with a queue-based reference model
module tb_toe_cam_arbiter;
   import toe_cam_pkg::*;

   localparam int DEPTH = 8;
   localparam int OW    = $clog2(DEPTH) + 1;

   logic            Clk = 1'b0;
   logic            Rst = 1'b0;
   logic            CamInitDone = 1'b0;
   logic [1:0]      LkpReqValid = '0;
   logic [2*K-1:0]  LkpReqKey = '0;
   logic [1:0]      LkpReqReady;
   logic            LookupReqValid;
   logic [K-1:0]    LookupReqKey;
   logic            LookupRespValid = 1'b0;
   logic            LookupRespHit = 1'b0;
   logic [K-1:0]    LookupRespKey = '0;
   logic [V-1:0]    LookupRespValue = '0;
   logic [1:0]      LkpRespValid;
   logic            LkpRespHit;
   logic [K-1:0]    LkpRespKey;
   logic [V-1:0]    LkpRespValue;
   logic [1:0]      UpdReqValid = '0;
   logic [1:0]      UpdReqOp = '0;
   logic [2*K-1:0]  UpdReqKey = '0;
   logic [1:0]      UpdReqStatic = '0;
   logic [2*V-1:0]  UpdReqValue = '0;
   logic [1:0]      UpdReqReady;
   logic            UpdateReady = 1'b0;
   logic            UpdateValid;
   logic            UpdateOp;
   logic [K-1:0]    UpdateKey;
   logic            UpdateStatic;
   logic [V-1:0]    UpdateValue;
   logic [OW-1:0]   Outstanding;
   logic            ProtoErr;

   always #5 Clk = ~Clk;

   toe_cam_arbiter #(.DEPTH(DEPTH)) dut (
      .Clk(Clk), .Rst(Rst), .CamInitDone(CamInitDone),
      .LkpReqValid(LkpReqValid), .LkpReqKey(LkpReqKey), .LkpReqReady(LkpReqReady),
      .LookupReqValid(LookupReqValid), .LookupReqKey(LookupReqKey),
      .LookupRespValid(LookupRespValid), .LookupRespHit(LookupRespHit),
      .LookupRespKey(LookupRespKey), .LookupRespValue(LookupRespValue),
      .LkpRespValid(LkpRespValid), .LkpRespHit(LkpRespHit),
      .LkpRespKey(LkpRespKey), .LkpRespValue(LkpRespValue),
      .UpdReqValid(UpdReqValid), .UpdReqOp(UpdReqOp), .UpdReqKey(UpdReqKey),
      .UpdReqStatic(UpdReqStatic), .UpdReqValue(UpdReqValue), .UpdReqReady(UpdReqReady),
      .UpdateReady(UpdateReady), .UpdateValid(UpdateValid), .UpdateOp(UpdateOp),
      .UpdateKey(UpdateKey), .UpdateStatic(UpdateStatic), .UpdateValue(UpdateValue),
      .Outstanding(Outstanding), .ProtoErr(ProtoErr)
   );

   typedef struct { logic src; logic [K-1:0] key; } lkp_t;
   typedef struct { logic [1:0] onehot; logic hit; logic [K-1:0] key; logic [V-1:0] value; } rsp_t;
   typedef struct { logic op; logic [K-1:0] key; logic st; logic [V-1:0] value; } upd_t;

   lkp_t         m_tags[$];
   logic [K-1:0] issue_q[$];
   rsp_t         resp_q[$];
   upd_t         upd_q[$];
   int           m_out = 0;
   bit           m_proto = 0;
   bit           m_slot = 0;
   bit           m_lkp_last = 1;
   bit           m_upd_last = 1;
   int           checks = 0;
   int           errors = 0;
   bit           mon_en = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [K-1:0] rand_key();
      return K'({$urandom(), $urandom(), $urandom()});
   endfunction

   // Lone requester wins; on conflict the client that did not win last time wins.
   function automatic logic [1:0] pick(input logic [1:0] v, input bit last, input bit ok);
      if (!ok || v == 2'b00) return 2'b00;
      if (v == 2'b11) return last ? 2'b01 : 2'b10;
      return v;
   endfunction

   // rsp: 0 none, 1 respond only if something is outstanding, 2 respond regardless
   task automatic cycle(input logic [1:0] lv, input int rsp, input logic [1:0] uv,
                        input bit urdy, input bit init);
      logic [1:0] eg, eu;
      lkp_t t;
      rsp_t r;
      upd_t u;
      bit   do_rsp;
      @(negedge Clk);
      do_rsp          = (rsp == 2) || (rsp == 1 && m_tags.size() > 0);
      CamInitDone     = init;
      LkpReqValid     = lv;
      LkpReqKey       = {rand_key(), rand_key()};
      LookupRespValid = do_rsp;
      LookupRespHit   = 1'($urandom_range(0, 1));
      LookupRespValue = V'($urandom());
      LookupRespKey   = (m_tags.size() > 0) ? m_tags[0].key : rand_key();
      UpdReqValid     = uv;
      UpdReqOp        = 2'($urandom());
      UpdReqKey       = {rand_key(), rand_key()};
      UpdReqStatic    = 2'($urandom());
      UpdReqValue     = {V'($urandom()), V'($urandom())};
      UpdateReady     = urdy;
      #1;
      eg = pick(lv, m_lkp_last, init && (m_out < DEPTH));
      chk("lkp_req_ready", LkpReqReady, eg);
      eu = pick(uv, m_upd_last, init && !m_slot);
      chk("upd_req_ready", UpdReqReady, eu);

      if (do_rsp) begin
         if (m_tags.size() == 0) begin
            m_proto = 1;
         end else begin
            t        = m_tags.pop_front();
            r.onehot = t.src ? 2'b10 : 2'b01;
            r.hit    = LookupRespHit;
            r.key    = LookupRespKey;
            r.value  = LookupRespValue;
            resp_q.push_back(r);
         end
      end
      if (eg != 2'b00) begin
         t.src = eg[1];
         t.key = eg[1] ? LkpReqKey[K +: K] : LkpReqKey[0 +: K];
         m_tags.push_back(t);
         issue_q.push_back(t.key);
         m_lkp_last = eg[1];
      end
      m_out = m_tags.size();

      if (m_slot && urdy) begin
         u = upd_q.pop_front();
         m_slot = 0;
      end else if (eu != 2'b00) begin
         u.op    = eu[1] ? UpdReqOp[1] : UpdReqOp[0];
         u.key   = eu[1] ? UpdReqKey[K +: K] : UpdReqKey[0 +: K];
         u.st    = eu[1] ? UpdReqStatic[1] : UpdReqStatic[0];
         u.value = eu[1] ? UpdReqValue[V +: V] : UpdReqValue[0 +: V];
         upd_q.push_back(u);
         m_slot     = 1;
         m_upd_last = eu[1];
      end
   endtask

   task automatic do_reset();
      @(negedge Clk);
      Rst = 1'b1;
      CamInitDone = 0; LkpReqValid = 0; LookupRespValid = 0; UpdReqValid = 0; UpdateReady = 0;
      m_tags.delete(); issue_q.delete(); resp_q.delete(); upd_q.delete();
      m_out = 0; m_proto = 0; m_slot = 0; m_lkp_last = 1; m_upd_last = 1;
      #1;
      chk("rst_lookup_req_valid", LookupReqValid, 1'b0);
      chk("rst_lkp_resp_valid", LkpRespValid, 2'b00);
      chk("rst_update_valid", UpdateValid, 1'b0);
      chk("rst_outstanding", Outstanding, '0);
      chk("rst_proto_err", ProtoErr, 1'b0);
      chk("rst_update_key", UpdateKey, '0);
      @(negedge Clk);
      Rst = 1'b0;
   endtask

   initial begin
      rsp_t r;
      forever begin
         @(posedge Clk);
         #1;
         if (mon_en) begin
            chk("outstanding", Outstanding, m_out);
            chk("proto_err", ProtoErr, m_proto);
            chk("lookup_req_valid", LookupReqValid, issue_q.size() != 0);
            if (issue_q.size() != 0)
               chk("lookup_req_key", LookupReqKey, issue_q.pop_front());
            chk("lkp_resp_valid", LkpRespValid, (resp_q.size() != 0) ? resp_q[0].onehot : 2'b00);
            if (resp_q.size() != 0) begin
               r = resp_q.pop_front();
               chk("lkp_resp_hit", LkpRespHit, r.hit);
               chk("lkp_resp_key", LkpRespKey, r.key);
               chk("lkp_resp_value", LkpRespValue, r.value);
            end
            chk("update_valid", UpdateValid, upd_q.size() != 0);
            if (upd_q.size() != 0) begin
               chk("update_op", UpdateOp, upd_q[0].op);
               chk("update_key", UpdateKey, upd_q[0].key);
               chk("update_static", UpdateStatic, upd_q[0].st);
               chk("update_value", UpdateValue, upd_q[0].value);
            end
         end
      end
   end

   initial begin
      do_reset();
      mon_en = 1;

      // single lookup, CAM answers three cycles after issue
      cycle(2'b01, 0, 2'b00, 0, 1);
      repeat (2) cycle(2'b00, 0, 2'b00, 0, 1);
      cycle(2'b00, 1, 2'b00, 0, 1);
      cycle(2'b00, 0, 2'b00, 0, 1);

      // contention then in-order replies
      repeat (6) cycle(2'b11, 0, 2'b00, 0, 1);
      repeat (8) cycle(2'b00, 1, 2'b00, 0, 1);

      // outstanding limit
      repeat (12) cycle(2'b01, 0, 2'b00, 0, 1);
      cycle(2'b01, 1, 2'b00, 0, 1);
      repeat (3) cycle(2'b01, 0, 2'b00, 0, 1);
      repeat (10) cycle(2'b00, 1, 2'b00, 0, 1);

      // update backpressure
      repeat (5) cycle(2'b00, 0, 2'b11, 0, 1);
      cycle(2'b00, 0, 2'b11, 1, 1);
      repeat (3) cycle(2'b00, 0, 2'b11, 0, 1);
      cycle(2'b00, 0, 2'b00, 1, 1);

      // init gating
      repeat (10) cycle(2'b11, 0, 2'b11, 0, 0);
      cycle(2'b00, 0, 2'b00, 1, 1);

      // randomized traffic with a reset in the middle
      for (int i = 0; i < 2000; i++) begin
         if (i == 1000) do_reset();
         cycle(2'($urandom()), ($urandom_range(0, 99) < 40) ? 1 : 0, 2'($urandom()),
               1'($urandom_range(0, 1)), $urandom_range(0, 99) < 95);
      end
      repeat (12) cycle(2'b00, 1, 2'b00, 1, 1);

      // spurious response is sticky until reset
      cycle(2'b00, 2, 2'b00, 0, 1);
      repeat (4) cycle(2'b00, 0, 2'b00, 0, 1);
      do_reset();
      repeat (2) cycle(2'b00, 0, 2'b00, 0, 1);

      @(negedge Clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/toe_cam_arbiter.md
Name: toe_cam_arbiter

Overview:
Shares the single ToeCam lookup port and single update port between two session-lookup clients (RX path = 0, TX path = 1) and two update clients (insert source = 0, delete/aging source = 1).
- Grants are round-robin.
- Lookups are tagged with their source in an in-order tag FIFO, so CAM responses are steered back to the originator.
- The number of lookups in flight is bounded.
- Sits between the TOE session-lookup controller and the CAM wrapper.

Parameters:
K, 96, lookup key width (bits)
V, 14, lookup/update value width (bits)
DEPTH, 8, max outstanding lookups / tag FIFO depth (power of 2, >=2)

Ports:
Clk  in  1  clock
Rst  in  1  reset, asynchronous, active-high
CamInitDone  in  1  CAM initialised; no grants while 0
LkpReqValid  in  2  per-client lookup request valid
LkpReqKey  in  2*K  client i key at [i*K +: K]
LkpReqReady  out  2  per-client grant (combinational)
LookupReqValid  out  1  to CAM, registered
LookupReqKey  out  K  to CAM, registered
LookupRespValid  in  1  from CAM
LookupRespHit  in  1  from CAM
LookupRespKey  in  K  from CAM
LookupRespValue  in  V  from CAM
LkpRespValid  out  2  one-hot response strobe to client
LkpRespHit  out  1  shared response hit
LkpRespKey  out  K  shared response key
LkpRespValue  out  V  shared response value
UpdReqValid  in  2  per-client update valid
UpdReqOp  in  2  0=insert, 1=delete
UpdReqKey  in  2*K  client i key at [i*K +: K]
UpdReqStatic  in  2  static-entry flag
UpdReqValue  in  2*V  client i value at [i*V +: V]
UpdReqReady  out  2  per-client grant (combinational)
UpdateReady  in  1  from CAM
UpdateValid  out  1  to CAM
UpdateOp  out  1  to CAM
UpdateKey  out  K  to CAM
UpdateStatic  out  1  to CAM
UpdateValue  out  V  to CAM
Outstanding  out  log2(DEPTH)+1  lookups in flight
ProtoErr  out  1  sticky: CAM response received with tag FIFO empty

Behaviour:
- Reset: every output 0; round-robin pointers point to client 0 (client 0 wins the first conflict); tag FIFO empty; ProtoErr cleared.
- Lookup issue condition: CamInitDone && Outstanding < DEPTH.
- Lookup grant:
  - One client valid -> that client is granted.
  - Both valid -> the client that did not win the last grant is granted.
  - LkpReqReady[i] = grant[i], combinational, same cycle as the request.
- Lookup issue timing: on the grant edge, LookupReqKey is loaded, LookupReqValid = 1 for exactly the next cycle, and the source id is pushed into the tag FIFO. One issue per cycle max; back-to-back issues are allowed.
- Outstanding counter:
  - +1 on issue.
  - -1 on LookupRespValid with tag FIFO non-empty.
  - Both in the same cycle -> unchanged.
  - Issue when Outstanding == DEPTH is blocked, even if a response arrives that cycle.
- Lookup response: on LookupRespValid with FIFO non-empty:
  - Pop the tag.
  - Next cycle: LkpRespValid[tag] = 1 for one cycle; Hit/Key/Value are registered copies of the CAM response.
  - Latency CAM response -> client response = 1 cycle. Clients have no backpressure and must accept.
- Spurious response: LookupRespValid with FIFO empty -> ProtoErr set (sticky until Rst); no LkpRespValid; counter unchanged.
- Update path: single-entry slot.
  - Accept condition: slot empty && CamInitDone.
  - Arbitration: round-robin, same rules as lookups, with an independent pointer.
  - UpdReqReady[i] = grant[i], combinational.
  - The granted fields load into the slot; UpdateValid = slot full.
  - All Update* outputs stay stable while UpdateValid && !UpdateReady.
  - The slot clears on UpdateValid && UpdateReady. No accept in the clear cycle, so max 1 update per 2 cycles.
- CamInitDone drops mid-operation: new grants stop. In-flight lookups still complete and the pending update stays presented.
- Rst mid-operation: all state is discarded asynchronously. The CAM shares Rst, so no stale responses arrive.

Decomposition:
- Package toe_cam_pkg holds:
  - constants K, V
  - source ids SRC_RX=0, SRC_TX=1, SRC_INS=0, SRC_DEL=1
  - op encoding OP_INSERT=0, OP_DELETE=1
- Sub-module toe_cam_tag_fifo: DEPTH x 1-bit synchronous FIFO with push/pop/empty/full and occupancy count.
  - Occupancy count drives Outstanding.
  - Same-cycle push+pop is allowed; a pop takes effect when not empty.

Test Plan:
- Single lookup: CamInitDone=1, LkpReqValid=01, key 0x1 -> LkpReqReady=01 same cycle; LookupReqValid=1 next cycle with key 0x1. CAM replies 3 cycles later with hit=1, value=0x0123 -> LkpRespValid=01, hit=1, value=0x0123 one cycle later; Outstanding goes 0->1->0.
- Contention: both clients valid for 6 cycles -> grants 0,1,0,1,0,1; CAM in-order replies are routed to clients 0,1,0,1,0,1.
- Outstanding limit: CAM withholds replies, client 0 valid continuously -> 8 issues; ready low from the 9th cycle on with Outstanding=8; one reply -> exactly one further issue.
- Update backpressure: both update clients valid, UpdateReady=0 for 5 cycles -> client 0 is granted; UpdateValid and fields are stable for 5 cycles. UpdateReady=1 -> slot clears; client 1 is granted the cycle after.
- Init gating: CamInitDone=0 with all clients valid for 10 cycles -> no readies, LookupReqValid=0, UpdateValid=0.
- Spurious response: LookupRespValid=1 with nothing outstanding -> ProtoErr=1 next cycle and stays 1; LkpRespValid=00; cleared only by Rst.
